change_dispense_ctrl: RTL and testbench

- Sequences the coin-return mechanism after a vending transaction.
- Takes the change owed in cents and emits one timed eject pulse per coin, largest denomination first (20, 10, 5), from a per-denomination coin inventory.
- Falls back to smaller coins when a denomination runs out.
- Sits between the vending FSM (change total, purchase event) and the coin-return LEDs/actuators; drives the remaining-change value to the bin2bcd/sseg path.

---
 rtl/change_dispense_ctrl.sv | 164 ++++++++++++++++
 tb/tb_change_dispense_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_ctrl.sv
// Coin-return sequencer: dispenses owed change as timed eject pulses, largest coin first,
// falling back to smaller coins when a denomination's inventory is empty.
module change_dispense_ctrl #(
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned CW        = 4,
  parameter int unsigned INIT5     = 10,
  parameter int unsigned INIT10    = 10,
  parameter int unsigned INIT20    = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    change_in,
  input  logic          refill,
  output logic          eject5,
  output logic          eject10,
  output logic          eject20,
  output logic          busy,
  output logic          done,
  output logic          err_short,
  output logic [7:0]    remaining,
  output logic [CW-1:0] cnt5,
  output logic [CW-1:0] cnt10,
  output logic [CW-1:0] cnt20
);

  localparam int unsigned TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EJECT  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [7:0]      remaining_nxt;
  logic [CW-1:0]   cnt5_nxt, cnt10_nxt, cnt20_nxt;
  logic            eject5_nxt, eject10_nxt, eject20_nxt;
  logic            busy_nxt, done_nxt, err_nxt;
  logic            pick20_c, pick10_c, pick5_c;

  // Greedy denomination choice; a coin is only eligible if it fits and is in stock.
  assign pick20_c = (remaining >= 8'd20) && (cnt20 != '0);
  assign pick10_c = !pick20_c && (remaining >= 8'd10) && (cnt10 != '0);
  assign pick5_c  = !pick20_c && !pick10_c && (remaining >= 8'd5) && (cnt5 != '0);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      remaining <= '0;
      cnt5      <= CW'(INIT5);
      cnt10     <= CW'(INIT10);
      cnt20     <= CW'(INIT20);
      eject5    <= 1'b0;
      eject10   <= 1'b0;
      eject20   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_short <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      remaining <= remaining_nxt;
      cnt5      <= cnt5_nxt;
      cnt10     <= cnt10_nxt;
      cnt20     <= cnt20_nxt;
      eject5    <= eject5_nxt;
      eject10   <= eject10_nxt;
      eject20   <= eject20_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err_short <= err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SELECT;
      SELECT:  state_nxt = (pick20_c || pick10_c || pick5_c) ? EJECT : DONE;
      EJECT:   if (timer == '0) state_nxt = GAP;
      GAP:     if (timer == '0) state_nxt = SELECT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    timer_nxt     = timer;
    remaining_nxt = remaining;
    cnt5_nxt      = cnt5;
    cnt10_nxt     = cnt10;
    cnt20_nxt     = cnt20;
    eject5_nxt    = 1'b0;
    eject10_nxt   = 1'b0;
    eject20_nxt   = 1'b0;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    err_nxt       = err_short;
    case (state)
      IDLE: begin
        if (refill) begin
          cnt5_nxt  = CW'(INIT5);
          cnt10_nxt = CW'(INIT10);
          cnt20_nxt = CW'(INIT20);
        end
        if (start) begin
          remaining_nxt = change_in;
          err_nxt       = 1'b0;
          busy_nxt      = 1'b1;
        end
      end
      SELECT: begin
        timer_nxt = TW'(PULSE_CYC - 1);
        if (pick20_c) begin
          remaining_nxt = remaining - 8'd20;
          cnt20_nxt     = cnt20 - CW'(1);
          eject20_nxt   = 1'b1;
        end else if (pick10_c) begin
          remaining_nxt = remaining - 8'd10;
          cnt10_nxt     = cnt10 - CW'(1);
          eject10_nxt   = 1'b1;
        end else if (pick5_c) begin
          remaining_nxt = remaining - 8'd5;
          cnt5_nxt      = cnt5 - CW'(1);
          eject5_nxt    = 1'b1;
        end else begin
          timer_nxt = '0;
          done_nxt  = 1'b1;
          if (remaining != 8'd0) err_nxt = 1'b1;
        end
      end
      EJECT: begin
        if (timer == '0) begin
          timer_nxt = TW'(GAP_CYC - 1);
        end else begin
          timer_nxt   = timer - TW'(1);
          eject5_nxt  = eject5;
          eject10_nxt = eject10;
          eject20_nxt = eject20;
        end
      end
      GAP: begin
        if (timer != '0) timer_nxt = timer - TW'(1);
      end
      DONE: begin
        busy_nxt = 1'b0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Bench for change_dispense_ctrl: three inventory configurations, a vector table,
// randomized transactions and a mid-eject reset, all checked against a coin-list model.
module tb_change_dispense_ctrl;

  localparam int unsigned P = 4;
  localparam int unsigned G = 4;

  typedef struct {
    bit e5; bit e10; bit e20; bit busy; bit done; bit err; int rem;
  } exp_t;

  typedef struct {
    int amt; bit rf; bit poke; int c20; int c10; int c5; int rem; bit err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] start_a, refill_a, e5_a, e10_a, e20_a, busy_a, done_a, err_a;
  logic [7:0] chg_a [3];
  logic [7:0] rem_a [3];
  logic [3:0] c5_a [3];
  logic [3:0] c10_a [3];
  logic [3:0] c20_a [3];

  int n_chk  = 0;
  int n_fail = 0;
  int n_txn  = 0;
  int m5 [3];
  int m10 [3];
  int m20 [3];
  int i5 [3]  = '{10, 10, 1};
  int i10 [3] = '{10, 10, 0};
  int i20 [3] = '{10, 1, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    change_dispense_ctrl #(
      .PULSE_CYC(P), .GAP_CYC(G), .CW(4),
      .INIT5 (g == 2 ? 1 : 10),
      .INIT10(g == 2 ? 0 : 10),
      .INIT20(g == 0 ? 10 : (g == 1 ? 1 : 0))
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start_a[g]), .change_in(chg_a[g]),
      .refill(refill_a[g]), .eject5(e5_a[g]), .eject10(e10_a[g]), .eject20(e20_a[g]),
      .busy(busy_a[g]), .done(done_a[g]), .err_short(err_a[g]), .remaining(rem_a[g]),
      .cnt5(c5_a[g]), .cnt10(c10_a[g]), .cnt20(c20_a[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(bit e5, bit e10, bit e20, bit b, bit d, bit er, int rem);
    exp_t e;
    e.e5 = e5; e.e10 = e10; e.e20 = e20; e.busy = b; e.done = d; e.err = er; e.rem = rem;
    return e;
  endfunction

  function automatic int dut_flags(int k);
    return int'({e5_a[k], e10_a[k], e20_a[k], busy_a[k], done_a[k], err_a[k]});
  endfunction

  task automatic chk_reset(input int k);
    chk($sformatf("reset k%0d flags", k), dut_flags(k), 0);
    chk($sformatf("reset k%0d remaining", k), int'(rem_a[k]), 0);
    chk($sformatf("reset k%0d cnt5", k), int'(c5_a[k]), i5[k]);
    chk($sformatf("reset k%0d cnt10", k), int'(c10_a[k]), i10[k]);
    chk($sformatf("reset k%0d cnt20", k), int'(c20_a[k]), i20[k]);
  endtask

  // Model: greedy coin list from inventory, then the cycle-by-cycle picture it implies.
  task automatic run_txn(input int k, input int amt, input bit rf, input bit poke);
    int   coins[$];
    exp_t ex[$];
    exp_t e;
    int   r, rr;
    n_txn++;
    if (rf) begin m5[k] = i5[k]; m10[k] = i10[k]; m20[k] = i20[k]; end
    r = amt;
    forever begin
      if (r >= 20 && m20[k] > 0) begin coins.push_back(20); r -= 20; m20[k]--; end
      else if (r >= 10 && m10[k] > 0) begin coins.push_back(10); r -= 10; m10[k]--; end
      else if (r >= 5 && m5[k] > 0) begin coins.push_back(5); r -= 5; m5[k]--; end
      else break;
    end
    ex.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, amt));
    rr = amt;
    foreach (coins[j]) begin
      rr -= coins[j];
      for (int p = 0; p < int'(P); p++)
        ex.push_back(mk(coins[j] == 5, coins[j] == 10, coins[j] == 20, 1'b1, 1'b0, 1'b0, rr));
      for (int q = 0; q < int'(G); q++)
        ex.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rr));
      ex.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rr));
    end
    ex.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, r != 0, r));
    ex.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r != 0, r));

    start_a[k]  = 1'b1;
    refill_a[k] = rf;
    chg_a[k]    = 8'(amt);
    for (int i = 0; i < ex.size(); i++) begin
      @(posedge clk); #1;
      start_a[k]  = 1'b0;
      refill_a[k] = 1'b0;
      if (poke && i == 1) begin
        start_a[k]  = 1'b1;
        refill_a[k] = 1'b1;
        chg_a[k]    = 8'd10;
      end
      e = ex[i];
      chk($sformatf("txn%0d k%0d cyc%0d flags", n_txn, k, i), dut_flags(k),
          int'({e.e5, e.e10, e.e20, e.busy, e.done, e.err}));
      chk($sformatf("txn%0d k%0d cyc%0d remaining", n_txn, k, i), int'(rem_a[k]), e.rem);
    end
    chk($sformatf("txn%0d k%0d cnt5", n_txn, k), int'(c5_a[k]), m5[k]);
    chk($sformatf("txn%0d k%0d cnt10", n_txn, k), int'(c10_a[k]), m10[k]);
    chk($sformatf("txn%0d k%0d cnt20", n_txn, k), int'(c20_a[k]), m20[k]);
  endtask

  vec_t vt [7];

  initial begin
    // amt, refill, poke, cnt20, cnt10, cnt5, remaining, err_short (instance 0, cumulative)
    vt[0] = '{35,  1'b0, 1'b1, 9,  9,  9,  0, 1'b0};
    vt[1] = '{7,   1'b0, 1'b0, 9,  9,  8,  2, 1'b1};
    vt[2] = '{0,   1'b0, 1'b0, 9,  9,  8,  0, 1'b0};
    vt[3] = '{60,  1'b1, 1'b0, 7,  10, 10, 0, 1'b0};
    vt[4] = '{255, 1'b0, 1'b0, 0,  0,  7,  0, 1'b0};
    vt[5] = '{4,   1'b0, 1'b0, 0,  0,  7,  4, 1'b1};
    vt[6] = '{23,  1'b1, 1'b0, 9,  10, 10, 3, 1'b1};

    reset_n  = 1'b0;
    start_a  = '0;
    refill_a = '0;
    for (int k = 0; k < 3; k++) begin
      chg_a[k] = 8'd0;
      m5[k] = i5[k]; m10[k] = i10[k]; m20[k] = i20[k];
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_reset(k);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      run_txn(0, vt[v].amt, vt[v].rf, vt[v].poke);
      chk($sformatf("vec%0d cnt20", v), int'(c20_a[0]), vt[v].c20);
      chk($sformatf("vec%0d cnt10", v), int'(c10_a[0]), vt[v].c10);
      chk($sformatf("vec%0d cnt5", v), int'(c5_a[0]), vt[v].c5);
      chk($sformatf("vec%0d remaining", v), int'(rem_a[0]), vt[v].rem);
      chk($sformatf("vec%0d err_short", v), int'(err_a[0]), int'(vt[v].err));
    end

    // Single 20 in stock: one 20 then three 10s.
    run_txn(1, 50, 1'b0, 1'b0);
    chk("fallback cnt20", int'(c20_a[1]), 0);
    chk("fallback cnt10", int'(c10_a[1]), 7);
    chk("fallback remaining", int'(rem_a[1]), 0);

    // Drain the lone 5, then refill and start together.
    run_txn(2, 10, 1'b0, 1'b0);
    chk("drain remaining", int'(rem_a[2]), 5);
    chk("drain err_short", int'(err_a[2]), 1);
    run_txn(2, 5, 1'b1, 1'b0);
    chk("refill+start remaining", int'(rem_a[2]), 0);
    chk("refill+start cnt5", int'(c5_a[2]), 0);

    for (int n = 0; n < 40; n++) begin
      run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 90)),
              $urandom_range(0, 3) == 0, 1'b0);
    end

    // Reset during the second cycle of an eject pulse.
    start_a[0]  = 1'b1;
    refill_a[0] = 1'b1;
    chg_a[0]    = 8'd35;
    repeat (3) begin
      @(posedge clk); #1;
      start_a[0]  = 1'b0;
      refill_a[0] = 1'b0;
    end
    chk("pre-reset eject20", int'(e20_a[0]), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk_reset(k);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
